// File: rtl/comp_instr_pkg.sv
// Shared types and helpers for the RV32IC fetch realignment stage.
package comp_instr_pkg;

  // Low two opcode bits that mark a full 32-bit instruction.
  localparam logic [1:0] OPC_FULL = 2'b11;

  typedef logic [15:0] halfword_t;
  typedef logic [1:0]  hwcnt_t;

  // A halfword starts a compressed instruction unless its low bits are 11.
  function automatic logic is_compressed(input halfword_t hw);
    return hw[1:0] != OPC_FULL;
  endfunction

endpackage

// File: rtl/comp_instr_hw_buf.sv
// Three-entry halfword shift buffer: entry 0 is the oldest halfword.
// A pop of one or two entries is applied first; the append then lands
// directly behind whatever remains.
module comp_instr_hw_buf
  import comp_instr_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_clear,
  input  logic      i_pop1,
  input  logic      i_pop2,
  input  logic      i_push1,
  input  logic      i_push2,
  input  halfword_t i_lo,
  input  halfword_t i_hi,
  output halfword_t o_hw0,
  output halfword_t o_hw1,
  output hwcnt_t    o_cnt
);

  halfword_t r_hw [3];
  hwcnt_t    r_cnt;
  halfword_t w_shift [3];
  halfword_t w_next [3];
  hwcnt_t    w_base;
  hwcnt_t    w_cntNext;

  assign o_hw0 = r_hw[0];
  assign o_hw1 = r_hw[1];
  assign o_cnt = r_cnt;

  // Drop the consumed halfwords and move the survivors to the front.
  always_comb begin
    w_shift[0] = r_hw[0];
    w_shift[1] = r_hw[1];
    w_shift[2] = r_hw[2];
    w_base     = r_cnt;
    if (i_pop2) begin
      w_shift[0] = r_hw[2];
      w_shift[1] = 16'h0;
      w_shift[2] = 16'h0;
      w_base     = r_cnt - 2'd2;
    end else if (i_pop1) begin
      w_shift[0] = r_hw[1];
      w_shift[1] = r_hw[2];
      w_shift[2] = 16'h0;
      w_base     = r_cnt - 2'd1;
    end
  end

  // Append the new halfword(s) right behind the surviving entries.
  always_comb begin
    w_next[0] = w_shift[0];
    w_next[1] = w_shift[1];
    w_next[2] = w_shift[2];
    w_cntNext = w_base;
    if (i_push2) begin
      w_cntNext = w_base + 2'd2;
      case (w_base)
        2'd0: begin
          w_next[0] = i_lo;
          w_next[1] = i_hi;
        end
        2'd1: begin
          w_next[1] = i_lo;
          w_next[2] = i_hi;
        end
        default: ;
      endcase
    end else if (i_push1) begin
      w_cntNext = w_base + 2'd1;
      case (w_base)
        2'd0:    w_next[0] = i_hi;
        2'd1:    w_next[1] = i_hi;
        2'd2:    w_next[2] = i_hi;
        default: ;
      endcase
    end
  end

  // Buffer storage; a clear empties it without touching the contents.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hw[0] <= 16'h0;
      r_hw[1] <= 16'h0;
      r_hw[2] <= 16'h0;
      r_cnt   <= 2'd0;
    end else if (i_clear) begin
      r_cnt   <= 2'd0;
    end else begin
      r_hw[0] <= w_next[0];
      r_hw[1] <= w_next[1];
      r_hw[2] <= w_next[2];
      r_cnt   <= w_cntNext;
    end
  end

endmodule

// File: rtl/comp_instr_aligner.sv
// Fetch-side realignment stage: turns word-aligned fetch words into a
// stream of 16/32-bit instructions tagged with their PC, including
// instructions that straddle a word and halfword-aligned redirects.
module comp_instr_aligner
  import comp_instr_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] f_addr,
  input  logic        f_valid,
  output logic        f_ready,
  input  logic [31:0] f_data,
  output logic        i_valid,
  input  logic        i_ready,
  output logic [31:0] i_data,
  output logic [31:0] i_pc,
  output logic        i_compressed
);

  logic [31:0] r_pc;
  logic [31:0] r_fAddr;
  logic        r_skip;
  halfword_t   w_hw0;
  halfword_t   w_hw1;
  hwcnt_t      w_cnt;
  logic        w_accept;
  logic        w_consume;
  logic        w_unusedBits;

  // Bit 0 of a redirect target is meaningless for halfword-aligned code.
  assign w_unusedBits = flush_pc[0];

  assign i_compressed = is_compressed(w_hw0);
  assign i_valid      = !flush && ((w_cnt >= 2'd1 && i_compressed) || w_cnt >= 2'd2);
  assign i_data       = i_compressed ? {16'h0, w_hw0} : {w_hw1, w_hw0};
  assign i_pc         = r_pc;
  assign f_addr       = r_fAddr;
  assign f_ready      = !flush && w_cnt <= 2'd1;
  assign w_accept     = f_valid && f_ready;
  assign w_consume    = i_valid && i_ready;

  comp_instr_hw_buf u_buf (
    .i_clk   (aclk),
    .i_rst   (areset),
    .i_clear (flush),
    .i_pop1  (w_consume && i_compressed),
    .i_pop2  (w_consume && !i_compressed),
    .i_push1 (w_accept && r_skip),
    .i_push2 (w_accept && !r_skip),
    .i_lo    (f_data[15:0]),
    .i_hi    (f_data[31:16]),
    .o_hw0   (w_hw0),
    .o_hw1   (w_hw1),
    .o_cnt   (w_cnt)
  );

  // Track the PC of the oldest halfword, the next fetch address and
  // whether the low half of the next fetch word must be skipped.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_pc    <= {RESET_PC[31:1], 1'b0};
      r_fAddr <= {RESET_PC[31:2], 2'b00};
      r_skip  <= RESET_PC[1];
    end else if (flush) begin
      r_pc    <= {flush_pc[31:1], 1'b0};
      r_fAddr <= {flush_pc[31:2], 2'b00};
      r_skip  <= flush_pc[1];
    end else begin
      if (w_consume) begin
        r_pc <= r_pc + (i_compressed ? 32'd2 : 32'd4);
      end
      if (w_accept) begin
        r_fAddr <= r_fAddr + 32'd4;
        r_skip  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/comp_instr_aligner.md
Name: comp_instr_aligner

Overview:
Fetch-side realignment stage for the RV32IC core. It sits between instruction memory and the compressed-instruction decode FSM/expander. It requests word-aligned 32-bit fetch words and splits them into a stream of 16-bit compressed or 32-bit instructions, each tagged with its PC. It handles 32-bit instructions that straddle a word boundary and branch redirects to halfword-aligned targets.

Parameters:
RESET_PC, 32'h0000_0000, PC after reset; bit 0 must be 0, bit 1 may be 1.

Ports:
aclk  in  1  clock; all state updates on the rising edge.
areset  in  1  asynchronous, active-high reset.
flush  in  1  redirect request; takes priority over all other activity.
flush_pc  in  32  redirect target; bit 0 ignored.
f_addr  out  32  word-aligned fetch address (bits [1:0]=0).
f_valid  in  1  fetch word valid.
f_ready  out  1  aligner accepts the fetch word this cycle.
f_data  in  32  fetch word; the halfword at f_addr is in [15:0].
i_valid  out  1  instruction available.
i_ready  in  1  downstream consumes the instruction.
i_data  out  32  instruction; compressed ones are zero-extended to {16'h0, hw}.
i_pc  out  32  PC of i_data.
i_compressed  out  1  1 when i_data[1:0] != 2'b11.

Behaviour:
- State:
  - 3-entry halfword buffer hw[0..2], with hw0 the oldest.
  - cnt in 0..3.
  - pc: address of hw0.
  - f_addr counter.
  - skip flag.
- Reset (async, whichever comes first):
  - cnt=0, hw*=0, pc=RESET_PC.
  - f_addr=RESET_PC & ~3.
  - skip=RESET_PC[1].
  - Resulting outputs: i_valid=0, i_data=0, i_compressed=1, f_ready=1.
- Output decode (combinational from registers only):
  - i_compressed = (hw0[1:0] != 2'b11).
  - i_valid = !flush && ((cnt>=1 && i_compressed) || cnt>=2).
  - i_data = i_compressed ? {16'h0,hw0} : {hw1,hw0}.
  - i_pc = pc.
- f_ready = !flush && cnt<=1. It depends only on registered cnt; there is no combinational path from i_ready.
- Fetch accept (f_valid && f_ready):
  - Appends f_data[15:0] then f_data[31:16] behind the remaining entries (+2).
  - If skip=1, appends only f_data[31:16] (+1) and clears skip.
  - f_addr += 4.
- Consume (i_valid && i_ready):
  - Removes 1 halfword (compressed) or 2 halfwords (32-bit) and shifts the rest down.
  - pc += 2 or pc += 4.
- Simultaneous accept and consume in one cycle: the consume shift is applied first, then the append. cnt_next = cnt - used + added; this never exceeds 3.
- Latency: a word accepted at edge N gives i_valid in the cycle after N. A straddling 32-bit instruction waits for the second word.
- Full: at cnt=2 or 3, f_ready=0. The buffer still drains via the consume path.
- Empty: i_valid=0. A 32-bit instruction with only its low halfword held (cnt=1, hw0[1:0]=11) also gives i_valid=0.
- Flush (sampled on the edge):
  - cnt=0, pc = {flush_pc[31:1],1'b0}.
  - f_addr = flush_pc & ~3.
  - skip = flush_pc[1].
  - Any fetch word or consume presented in the flush cycle is discarded: f_ready=0 and i_valid=0 that cycle.
- Wrap-around: pc and f_addr wrap modulo 2^32 with no special handling.
- Reset mid-operation: all state returns to reset values immediately; partial instructions are lost.
- Decoding legality (e.g. all-zero halfwords) is not checked here; that belongs to decode.

Decomposition:
- Shared package comp_instr_pkg:
  - OPC_FULL=2'b11.
  - halfword_t (logic [15:0]).
  - hwcnt_t (logic [1:0]).
  - Helper function is_compressed(halfword_t).
- One sub-module, comp_instr_hw_buf: the 3-entry halfword shift buffer with push1/push2/pop1/pop2 and cnt.
- The top level holds the pc, f_addr and skip logic, the handshakes and the flush.

Test Plan:
- RESET_PC=0; f_data=32'h00B5_0533 at f_addr 0 -> next cycle: i_valid=1, i_data=32'h00B50533, i_pc=0, i_compressed=0; f_addr=4.
- f_data=32'h0505_4501 with i_ready=1 -> 32'h0000_4501 at pc 0, then 32'h0000_0505 at pc 2; f_ready=1 throughout after the second consume.
- Straddle: words 32'h0533_4501 then 32'h4501_00B5:
  - 32'h4501 at pc 0.
  - 32'h00B50533 at pc 2, valid only after the second word is accepted.
  - 32'h4501 at pc 6.
- Backpressure: i_ready=0 with f_valid=1 -> f_ready drops once cnt>=2; i_data/i_pc held stable; no word lost when i_ready returns to 1.
- Flush at cnt=3 with flush_pc=32'h102 -> next cycle: cnt=0, i_valid=0, f_addr=32'h100. Then word 32'h0001_4501 -> only 32'h0000_0001 is emitted, at pc 32'h102.
- Assert areset mid-straddle, with RESET_PC=32'h2 -> i_valid=0 immediately (asynchronously), f_addr=0. First word's high half is emitted at pc 2.
